// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the camera-to-VGA triple frame buffer controller.
package frame_buf_pkg;

  // Pixels in one complete 640x480 frame.
  localparam int FRAME_PIXELS_DEF = 307200;

  // Camera-side write FSM.
  typedef enum logic [1:0] {
    CAM_IDLE   = 2'd0,
    CAM_WRITE  = 2'd1,
    CAM_FROZEN = 2'd2
  } cam_state_e;

  // Index of one of the three frame banks (0..2).
  typedef logic [1:0] bank_t;

  localparam bank_t WR_BANK_RST  = 2'd0;
  localparam bank_t RD_BANK_RST  = 2'd1;
  localparam bank_t RDY_BANK_RST = 2'd2;

  // The bank that is neither a nor b (banks are 0,1,2 so they sum to 3).
  function automatic bank_t third_bank(input bank_t a, input bank_t b);
    third_bank = 2'd3 - a - b;
  endfunction

  // Increment an 8-bit counter, holding at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/frame_pix_cnt.sv
// Per-frame pixel counter: saturates at FRAME_PIXELS, tracks an out-of-range
// write flag, and both are cleared at every camera frame start.
module frame_pix_cnt
  import frame_buf_pkg::*;
#(
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
  input  logic cam_in_clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic inc_i,
  input  logic bad_i,
  output logic full_o,
  output logic bad_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_PIXELS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;

  // Next count: clear has priority over a pixel arriving in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    bad_d = bad_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
      bad_d = 1'b0;
    end else begin
      if (inc_i && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
        cnt_d = cnt_q;
      end
      bad_d = bad_q | bad_i;
    end
  end

  // Counter and bad-flag registers.
  always_ff @(posedge cam_in_clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= {CNT_W{1'b0}};
      bad_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bad_q <= bad_d;
    end
  end

  assign full_o = (cnt_q == CNT_MAX);
  assign bad_o  = bad_q;

endmodule

// File: rtl/frame_buf_ctrl.sv
// Triple-buffer controller between a camera writer and a VGA reader.
// Bank W receives camera pixels, bank D is displayed, bank L holds the latest
// completed frame until VGA picks it up at its next frame start.
module frame_buf_ctrl
  import frame_buf_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 12,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
  input  logic              cam_in_clk,
  input  logic              rstn,
  input  logic              cam_frame_start,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [DATA_W-1:0] cam_data,
  input  logic              vga_frame_start,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              freeze,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W+1:0] mem_raddr,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic              ready_valid,
  output logic [7:0]        drop_cnt,
  output logic [15:0]       frame_cnt
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(FRAME_PIXELS);

  cam_state_e        state_q, state_d;
  bank_t             wr_bank_q, wr_bank_d;
  bank_t             rd_bank_q, rd_bank_d;
  bank_t             rdy_bank_q, rdy_bank_d;
  logic              ready_valid_q, ready_valid_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W+1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W+1:0] mem_raddr_q, mem_raddr_d;

  logic addr_in_range_s;
  logic pix_acc_s;
  logic pix_bad_s;
  logic pix_full_s;
  logic pix_bad_flag_s;
  logic frame_ok_s;

  assign addr_in_range_s = ({1'b0, cam_addr} < ADDR_LIMIT);
  assign pix_acc_s       = (state_q == CAM_WRITE) && cam_we && addr_in_range_s;
  assign pix_bad_s       = (state_q == CAM_WRITE) && cam_we && !addr_in_range_s;
  assign frame_ok_s      = pix_full_s && !pix_bad_flag_s;

  frame_pix_cnt #(
    .FRAME_PIXELS(FRAME_PIXELS)
  ) u_pix_cnt (
    .cam_in_clk(cam_in_clk),
    .rstn      (rstn),
    .clr_i     (cam_frame_start),
    .inc_i     (pix_acc_s),
    .bad_i     (pix_bad_s),
    .full_o    (pix_full_s),
    .bad_o     (pix_bad_flag_s)
  );

  // Bank rotation and FSM next state: the VGA pickup is resolved first so a
  // same-cycle camera completion picks its new write bank against the new D.
  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    rdy_bank_d    = rdy_bank_q;
    ready_valid_d = ready_valid_q;
    drop_cnt_d    = drop_cnt_q;
    frame_cnt_d   = frame_cnt_q;

    if (vga_frame_start && ready_valid_q) begin
      rd_bank_d     = rdy_bank_q;
      ready_valid_d = 1'b0;
    end else begin
      rd_bank_d     = rd_bank_q;
    end

    if (cam_frame_start) begin
      case (state_q)
        CAM_WRITE: begin
          if (frame_ok_s) begin
            rdy_bank_d    = wr_bank_q;
            wr_bank_d     = third_bank(wr_bank_q, rd_bank_d);
            ready_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
          end else begin
            drop_cnt_d    = sat_inc8(drop_cnt_q);
          end
        end
        CAM_IDLE, CAM_FROZEN: begin
          wr_bank_d = wr_bank_q;
        end
        default: begin
          wr_bank_d = wr_bank_q;
        end
      endcase
      if (freeze) begin
        state_d = CAM_FROZEN;
      end else begin
        state_d = CAM_WRITE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Memory port next values: the write bank is captured together with the
  // pixel, so a swap on the same edge cannot split bank and address.
  always_comb begin
    mem_we_d    = pix_acc_s;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    if (pix_acc_s) begin
      mem_waddr_d = {wr_bank_q, cam_addr};
      mem_wdata_d = cam_data;
    end else begin
      mem_waddr_d = mem_waddr_q;
      mem_wdata_d = mem_wdata_q;
    end
    mem_raddr_d = {rd_bank_d, vga_addr};
  end

  // Single state/output register block for the camera FSM and buffer control.
  always_ff @(posedge cam_in_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= CAM_IDLE;
      wr_bank_q     <= WR_BANK_RST;
      rd_bank_q     <= RD_BANK_RST;
      rdy_bank_q    <= RDY_BANK_RST;
      ready_valid_q <= 1'b0;
      drop_cnt_q    <= 8'd0;
      frame_cnt_q   <= 16'd0;
      mem_we_q      <= 1'b0;
      mem_waddr_q   <= {(ADDR_W + 2){1'b0}};
      mem_wdata_q   <= {DATA_W{1'b0}};
      mem_raddr_q   <= {RD_BANK_RST, {ADDR_W{1'b0}}};
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      rdy_bank_q    <= rdy_bank_d;
      ready_valid_q <= ready_valid_d;
      drop_cnt_q    <= drop_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      mem_we_q      <= mem_we_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_raddr_q   <= mem_raddr_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_waddr   = mem_waddr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_raddr   = mem_raddr_q;
  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign ready_valid = ready_valid_q;
  assign drop_cnt    = drop_cnt_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
